snes_osd_overlay: RTL and testbench

Pixel-domain on-screen-display mixer placed directly downstream of the brightness-scaled digital RGB path (9-bit R/G/B per channel) and upstream of the video DAC pins. It tracks the active-video raster from the PPU blanking strobes, holds a writable character map, fetches glyph rows from the external font ROM through a fixed-latency pipeline, and mixes dimmed background plus glyph foreground into the outgoing RGB stream. Video passing through has constant latency, both inside and outside the OSD window.

---
 rtl/osd_pkg.sv | 31 +++
 rtl/osd_char_ram.sv | 25 ++
 rtl/snes_osd_overlay.sv | 149 ++++++++++++++
 tb/tb_snes_osd_overlay.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared constants and types for the SNES on-screen-display overlay.
package osd_pkg;

  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned DOT_REP    = 2;
  localparam int unsigned PIPE_DEPTH = 4;
  localparam int unsigned MAP_AW     = 7;

  typedef struct packed {
    logic [8:0] r;
    logic [8:0] g;
    logic [8:0] b;
  } rgb_t;

  // One dot travelling down the fetch pipeline.
  typedef struct packed {
    logic                       win;
    logic [$clog2(GLYPH_W)-1:0] bit_sel;
    logic [7:0]                 line;
    rgb_t                       pix;
  } dot_t;

  function automatic rgb_t dim(input rgb_t c);
    rgb_t d;
    d.r = {1'b0, c.r[8:1]};
    d.g = {1'b0, c.g[8:1]};
    d.b = {1'b0, c.b[8:1]};
    return d;
  endfunction

endpackage

// File: rtl/osd_char_ram.sv
// Character map: synchronous 1R1W RAM, read returns old data on collision.
module osd_char_ram #(
  parameter int unsigned DEPTH = 96,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 7
) (
  input  logic          mclock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge mclock) begin
    if (wr_en && (32'(wr_addr) < DEPTH))
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/snes_osd_overlay.sv
// OSD mixer: raster tracking, char-map + font fetch pipeline, and RGB mix
// with a fixed 4-clock video latency.
module snes_osd_overlay
  import osd_pkg::*;
#(
  parameter int unsigned OSD_X1  = 64,
  parameter int unsigned OSD_Y1  = 40,
  parameter int unsigned COLS    = 24,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned GLYPH_H = 12,
  parameter logic [8:0]  FG      = 9'd465
) (
  input  logic        CLK_i,
  input  logic        NRST_i,
  input  logic        PIX_EN_i,
  input  logic        HBLANK_i,
  input  logic        VBLANK_i,
  input  logic [8:0]  R_i,
  input  logic [8:0]  G_i,
  input  logic [8:0]  B_i,
  input  logic        OSD_EN_i,
  input  logic        WR_EN_i,
  input  logic [6:0]  WR_ADDR_i,
  input  logic [6:0]  WR_DATA_i,
  output logic [10:0] FONT_ADDR_o,
  input  logic [7:0]  FONT_DATA_i,
  output logic [8:0]  R_o,
  output logic [8:0]  G_o,
  output logic [8:0]  B_o,
  output logic        OSD_ACTIVE_o
);

  localparam int unsigned MAP_DEPTH = COLS * ROWS;
  localparam int unsigned X2        = OSD_X1 + COLS * GLYPH_W * DOT_REP;
  localparam int unsigned Y2        = OSD_Y1 + ROWS * GLYPH_H;
  localparam int unsigned REP_SH    = $clog2(DOT_REP);
  localparam int unsigned CELL_SH   = $clog2(GLYPH_W * DOT_REP);
  localparam int unsigned LAST      = PIPE_DEPTH - 1;

  logic [8:0]            h_cnt, v_cnt, dx;
  logic [7:0]            line_cnt;
  logic [6:0]            row_cnt;
  logic                  hblank_q, osd_en_q, win_now;
  logic [MAP_AW-1:0]     map_addr_now, s0_map_addr;
  logic [6:0]            ram_code;
  logic [PIPE_DEPTH-1:0] vld;
  dot_t                  st [PIPE_DEPTH];
  rgb_t                  mixed;

  assign dx      = h_cnt - 9'(OSD_X1);
  assign win_now = osd_en_q
                && (h_cnt >= 9'(OSD_X1)) && (32'(h_cnt) < X2)
                && (v_cnt >= 9'(OSD_Y1)) && (32'(v_cnt) < Y2);
  assign map_addr_now = win_now
                      ? MAP_AW'(32'(row_cnt) * COLS + 32'(dx >> CELL_SH))
                      : '0;

  // Row/line of the glyph are stepped with v_cnt instead of dividing dy.
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      line_cnt <= '0;
      row_cnt  <= '0;
      hblank_q <= 1'b0;
      osd_en_q <= 1'b0;
    end else begin
      hblank_q <= HBLANK_i;
      if (HBLANK_i)
        h_cnt <= '0;
      else if (PIX_EN_i && (h_cnt != '1))
        h_cnt <= h_cnt + 9'd1;
      if (VBLANK_i) begin
        v_cnt    <= '0;
        line_cnt <= '0;
        row_cnt  <= '0;
        osd_en_q <= OSD_EN_i;
      end else if (HBLANK_i && !hblank_q && (v_cnt != '1)) begin
        v_cnt <= v_cnt + 9'd1;
        if (v_cnt >= 9'(OSD_Y1)) begin
          if (line_cnt == 8'(GLYPH_H - 1)) begin
            line_cnt <= '0;
            if (row_cnt != '1)
              row_cnt <= row_cnt + 7'd1;
          end else begin
            line_cnt <= line_cnt + 8'd1;
          end
        end
      end
    end
  end

  osd_char_ram #(
    .DEPTH (MAP_DEPTH),
    .AW    (MAP_AW),
    .DW    (7)
  ) u_char_ram (
    .mclock  (CLK_i),
    .wr_en   (WR_EN_i),
    .wr_addr (WR_ADDR_i),
    .wr_data (WR_DATA_i),
    .rd_en   (vld[0]),
    .rd_addr (s0_map_addr),
    .rd_data (ram_code)
  );

  always_comb begin
    mixed = st[LAST].pix;
    if (st[LAST].win)
      mixed = FONT_DATA_i[st[LAST].bit_sel] ? rgb_t'{r: FG, g: FG, b: FG}
                                            : dim(st[LAST].pix);
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      vld          <= '0;
      s0_map_addr  <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++)
        st[k] <= '0;
      FONT_ADDR_o  <= '0;
      R_o          <= '0;
      G_o          <= '0;
      B_o          <= '0;
      OSD_ACTIVE_o <= 1'b0;
    end else begin
      vld <= {vld[PIPE_DEPTH-2:0], PIX_EN_i};
      if (PIX_EN_i) begin
        s0_map_addr    <= map_addr_now;
        st[0].win      <= win_now;
        st[0].bit_sel  <= 3'(dx >> REP_SH);
        st[0].line     <= line_cnt;
        st[0].pix      <= '{r: R_i, g: G_i, b: B_i};
      end
      for (int unsigned k = 1; k < PIPE_DEPTH; k++)
        if (vld[k-1])
          st[k] <= st[k-1];
      // Map code from the RAM is valid only while stage 1 is occupied.
      if (vld[1] && st[1].win)
        FONT_ADDR_o <= 11'(32'(ram_code) * GLYPH_H + 32'(st[1].line));
      if (vld[LAST]) begin
        R_o          <= mixed.r;
        G_o          <= mixed.g;
        B_o          <= mixed.b;
        OSD_ACTIVE_o <= st[LAST].win;
      end
    end
  end

endmodule

// File: tb/tb_snes_osd_overlay.sv
// Directed self-checking bench for snes_osd_overlay with a font ROM model
// returning address[7:0] one clock after the address.
module tb_snes_osd_overlay;

  localparam int unsigned FG = 465;

  logic        CLK_i = 1'b0;
  logic        NRST_i, PIX_EN_i, HBLANK_i, VBLANK_i, OSD_EN_i, WR_EN_i;
  logic [8:0]  R_i, G_i, B_i, R_o, G_o, B_o;
  logic [6:0]  WR_ADDR_i, WR_DATA_i;
  logic [10:0] FONT_ADDR_o;
  logic [7:0]  FONT_DATA_i = '0;
  logic        OSD_ACTIVE_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cur_h = 0;
  int unsigned cur_v = 0;

  always #5 CLK_i = ~CLK_i;

  always @(posedge CLK_i) FONT_DATA_i <= FONT_ADDR_o[7:0];

  snes_osd_overlay #(
    .OSD_X1  (64),
    .OSD_Y1  (40),
    .COLS    (24),
    .ROWS    (4),
    .GLYPH_H (12),
    .FG      (9'd465)
  ) dut (
    .CLK_i        (CLK_i),
    .NRST_i       (NRST_i),
    .PIX_EN_i     (PIX_EN_i),
    .HBLANK_i     (HBLANK_i),
    .VBLANK_i     (VBLANK_i),
    .R_i          (R_i),
    .G_i          (G_i),
    .B_i          (B_i),
    .OSD_EN_i     (OSD_EN_i),
    .WR_EN_i      (WR_EN_i),
    .WR_ADDR_i    (WR_ADDR_i),
    .WR_DATA_i    (WR_DATA_i),
    .FONT_ADDR_o  (FONT_ADDR_o),
    .FONT_DATA_i  (FONT_DATA_i),
    .R_o          (R_o),
    .G_o          (G_o),
    .B_o          (B_o),
    .OSD_ACTIVE_o (OSD_ACTIVE_o)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  function automatic logic [26:0] vin(input int unsigned h, input int unsigned v);
    return {9'(h * 5 + v), 9'(h * 3 + 7), 9'(511 - h)};
  endfunction

  // One dot with 5-clock spacing; an optional map write lands on the read cycle.
  task automatic drive_dot(input logic we, input logic [6:0] wa, input logic [6:0] wd);
    logic [26:0] p;
    p = vin(cur_h, cur_v);
    {R_i, G_i, B_i} = p;
    PIX_EN_i = 1'b1;
    tick();
    PIX_EN_i  = 1'b0;
    WR_EN_i   = we;
    WR_ADDR_i = wa;
    WR_DATA_i = wd;
    tick();
    WR_EN_i = 1'b0;
    tick();
    tick();
    tick();
    cur_h++;
  endtask

  task automatic run_to(input int unsigned h);
    while (cur_h <= h) drive_dot(1'b0, 7'd0, 7'd0);
  endtask

  task automatic chk_dot(input string tag, input int unsigned h, input logic win, input logic gbit);
    logic [26:0] p;
    int unsigned er, eg, eb;
    p  = vin(h, cur_v);
    er = p[26:18];
    eg = p[17:9];
    eb = p[8:0];
    if (win) begin
      if (gbit) begin
        er = FG; eg = FG; eb = FG;
      end else begin
        er = er / 2; eg = eg / 2; eb = eb / 2;
      end
    end
    chk($sformatf("%s_r", tag), R_o, er);
    chk($sformatf("%s_g", tag), G_o, eg);
    chk($sformatf("%s_b", tag), B_o, eb);
    chk($sformatf("%s_act", tag), OSD_ACTIVE_o, win);
  endtask

  task automatic new_line();
    HBLANK_i = 1'b1;
    tick();
    tick();
    HBLANK_i = 1'b0;
    tick();
    cur_h = 0;
    cur_v++;
  endtask

  task automatic goto_line(input int unsigned v);
    while (cur_v < v) new_line();
  endtask

  task automatic start_frame(input logic en);
    OSD_EN_i = en;
    VBLANK_i = 1'b1;
    tick();
    tick();
    tick();
    VBLANK_i = 1'b0;
    tick();
    cur_v = 0;
    cur_h = 0;
  endtask

  task automatic write_map(input logic [6:0] a, input logic [6:0] d);
    WR_EN_i   = 1'b1;
    WR_ADDR_i = a;
    WR_DATA_i = d;
    tick();
    WR_EN_i = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  g60;
    logic [26:0] p;
    g60 = 8'd60;
    NRST_i = 1'b0; PIX_EN_i = 1'b0; HBLANK_i = 1'b0; VBLANK_i = 1'b0;
    OSD_EN_i = 1'b0; WR_EN_i = 1'b0; WR_ADDR_i = '0; WR_DATA_i = '0;
    R_i = '0; G_i = '0; B_i = '0;

    // Inputs toggle under reset; every output must stay 0.
    for (int i = 0; i < 12; i++) begin
      PIX_EN_i = (i % 4 == 0);
      HBLANK_i = i[1];
      VBLANK_i = i[2];
      OSD_EN_i = 1'b1;
      R_i = 9'($urandom); G_i = 9'($urandom); B_i = 9'($urandom);
      tick();
      if (i % 4 == 3) begin
        chk("rst_r", R_o, 0);
        chk("rst_g", G_o, 0);
        chk("rst_b", B_o, 0);
        chk("rst_act", OSD_ACTIVE_o, 0);
        chk("rst_font", FONT_ADDR_o, 0);
      end
    end
    PIX_EN_i = 1'b0; HBLANK_i = 1'b0; VBLANK_i = 1'b0; OSD_EN_i = 1'b0;
    tick();
    NRST_i = 1'b1;
    tick();

    for (int a = 0; a < 96; a++) write_map(7'(a), 7'd0);
    write_map(7'd0, 7'd5);
    write_map(7'd3, 7'd2);
    write_map(7'd4, 7'd3);
    write_map(7'd24, 7'd1);

    // Frame A: overlay disabled, check latency and pass-through.
    start_frame(1'b0);
    new_line();
    p = vin(0, cur_v);
    {R_i, G_i, B_i} = p;
    PIX_EN_i = 1'b1;
    tick();
    PIX_EN_i = 1'b0;
    tick();
    tick();
    tick();
    chk("lat_hold_r", R_o, 0);
    tick();
    chk_dot("lat4", 0, 1'b0, 1'b0);
    cur_h = 1;
    run_to(5);
    chk_dot("pass_v1", 5, 1'b0, 1'b0);
    goto_line(40);
    run_to(64);
    chk_dot("off_en0", 64, 1'b0, 1'b0);

    // Frame B: overlay enabled.
    start_frame(1'b1);
    goto_line(39);
    run_to(64);
    chk_dot("above", 64, 1'b0, 1'b0);

    new_line();
    run_to(63);
    chk_dot("left_out", 63, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      run_to(64 + k);
      chk_dot($sformatf("glyph%0d", k), 64 + k, 1'b1, g60[k / 2]);
      if (k == 0) chk("font_r0l0", FONT_ADDR_o, 60);
    end
    run_to(447);
    chk_dot("right_in", 447, 1'b1, 1'b0);
    run_to(448);
    chk_dot("right_out", 448, 1'b0, 1'b0);

    new_line();
    write_map(7'd100, 7'd50);
    run_to(111);
    drive_dot(1'b1, 7'd3, 7'd9);
    chk("coll_old", FONT_ADDR_o, 25);
    chk_dot("coll_pix", 112, 1'b1, 1'b1);
    run_to(128);
    chk("oob_wr", FONT_ADDR_o, 37);
    chk_dot("col4", 128, 1'b1, 1'b1);

    new_line();
    run_to(112);
    chk("coll_new", FONT_ADDR_o, 110);
    chk_dot("coll_new_pix", 112, 1'b1, 1'b0);
    OSD_EN_i = 1'b0;

    goto_line(52);
    run_to(64);
    chk("font_r1l0", FONT_ADDR_o, 12);
    chk_dot("latch52", 64, 1'b1, 1'b0);
    goto_line(63);
    run_to(64);
    chk("font_r1l11", FONT_ADDR_o, 23);
    chk_dot("latch63", 64, 1'b1, 1'b1);
    goto_line(87);
    run_to(64);
    chk("font_r3l11", FONT_ADDR_o, 11);
    chk_dot("last_line", 64, 1'b1, 1'b1);
    goto_line(88);
    run_to(64);
    chk_dot("below", 64, 1'b0, 1'b0);

    // Frame C: enable was dropped, overlay gone after VBLANK.
    start_frame(1'b0);
    goto_line(40);
    run_to(64);
    chk_dot("latched_off", 64, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
